// File: rtl/spram_arb_pkg.sv
// spram_arb_pkg: shared types and constants for the single-port RAM arbiter.
//   arb_state_t  - sequencer states (IDLE, ACCESS, RESP)
//   NUM_REQ      - number of clients
//   spram_req_t  - one latched client request (we, addr, wdata). The fields
//                  are sized for the widest supported configuration and
//                  users take the low ADDR_WIDTH / DATA_WIDTH bits.
package spram_arb_pkg;

    localparam int NUM_REQ        = 2;
    localparam int MAX_ADDR_WIDTH = 16;
    localparam int MAX_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic                      we;
        logic [MAX_ADDR_WIDTH-1:0] addr;
        logic [MAX_DATA_WIDTH-1:0] wdata;
    } spram_req_t;

endpackage

// File: rtl/spram_rr_arb.sv
// spram_rr_arb: 2-way round-robin picker, purely combinational.
//   req[1:0] in  - pending request per client
//   ptr      in  - client preferred when both request
//   gnt[1:0] out - one-hot grant (all zero when no request)
// The pointer register lives in the parent so it only moves on real grants.
module spram_rr_arb
    import spram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        // NOTE: every output of an always_comb gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        gnt = req;
        if (&req) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// spram_arbiter: two-client round-robin arbiter and sequencer for a
// single-port RAM with a registered read output.
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   req, we             - per-client request and write(1)/read(0) select
//   addr0/1, wdata0/1   - per-client address and write data
//   done                - one-cycle completion pulse to the served client
//   err                 - qualifies done: address >= DEPTH, RAM not accessed
//   rdata               - read data, valid with done on a read, else 0
//   ram_en, ram_addr,
//   ram_wdata, ram_rdata - RAM port (ram_en = 1 writes)
// Write completes one cycle after the granting edge, read two cycles.
// The RAM contents are not reset by this block.
// Optional: define SPRAM_ARB_STATS_EN to add gnt_cnt0/gnt_cnt1, saturating
// 16-bit counts of completed transactions per client.
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    we,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [NUM_REQ-1:0]    done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef SPRAM_ARB_STATS_EN
    ,
    output logic [15:0]           gnt_cnt0,
    output logic [15:0]           gnt_cnt1
`endif
);

    // DEPTH at the struct's address width plus one, so the range compare is
    // a plain unsigned compare with no truncation.
    localparam logic [MAX_ADDR_WIDTH:0] DEPTH_EXT = (MAX_ADDR_WIDTH + 1)'(DEPTH);

    arb_state_t          state_q, state_d;
    logic                owner_q, owner_d;  // client being served
    logic                ptr_q, ptr_d;      // client preferred on a tie
    spram_req_t          req_q, req_d;      // latched request of the owner
    logic                oor_q, oor_d;      // latched address was out of range
    spram_req_t          client_req [NUM_REQ];
    logic [NUM_REQ-1:0]  gnt;
    logic                win;
    logic                win_in_range;
    logic                owner_done;

    always_comb begin
        client_req[0]                        = '0;
        client_req[1]                        = '0;
        client_req[0].we                     = we[0];
        client_req[1].we                     = we[1];
        client_req[0].addr[ADDR_WIDTH-1:0]   = addr0;
        client_req[1].addr[ADDR_WIDTH-1:0]   = addr1;
        client_req[0].wdata[DATA_WIDTH-1:0]  = wdata0;
        client_req[1].wdata[DATA_WIDTH-1:0]  = wdata1;
    end

    spram_rr_arb u_rr_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    assign win          = gnt[1];
    assign win_in_range = ({1'b0, client_req[win].addr} < DEPTH_EXT);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        req_d   = req_q;
        oor_d   = oor_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = win;
                    ptr_d   = ~win;
                    req_d   = client_req[win];
                    oor_d   = !win_in_range;
                    state_d = ACCESS;
                end
            end
            // Writes and rejected accesses finish here; reads wait one more
            // cycle for the RAM's registered output.
            ACCESS:  state_d = (req_q.we || oor_q) ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the latched request is reset too, so ram_addr and
            // ram_wdata come out of reset at 0 rather than unknown.
            state_q <= IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            req_q   <= '0;
            oor_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks, so every
            // flop samples the pre-edge value of the others.
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            req_q   <= req_d;
            oor_q   <= oor_d;
        end
    end

    // Outputs decode straight from registered state; an asynchronous reset
    // therefore drops ram_en and done immediately, aborting a write.
    always_comb begin
        owner_done    = ((state_q == ACCESS) && (req_q.we || oor_q)) || (state_q == RESP);
        done          = '0;
        done[owner_q] = owner_done;
    end

    assign err       = (state_q == ACCESS) && oor_q;
    assign ram_en    = (state_q == ACCESS) && req_q.we && !oor_q;
    assign ram_addr  = req_q.addr[ADDR_WIDTH-1:0];
    assign ram_wdata = req_q.wdata[DATA_WIDTH-1:0];
    assign rdata     = (state_q == RESP) ? ram_rdata : '0;

    // Upper struct bits beyond this instance's widths are intentionally
    // dropped.
    logic unused_req_bits;
    assign unused_req_bits = ^{req_q.addr, req_q.wdata};

`ifdef SPRAM_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] gnt_cnt_q, gnt_cnt_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_cnt_d[i] = gnt_cnt_q[i];
            if (done[i] && (gnt_cnt_q[i] != 16'hFFFF)) begin
                gnt_cnt_d[i] = gnt_cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt_q <= '0;
        end else begin
            gnt_cnt_q <= gnt_cnt_d;
        end
    end

    assign gnt_cnt0 = gnt_cnt_q[0];
    assign gnt_cnt1 = gnt_cnt_q[1];
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: self-checking bench for spram_arbiter. A behavioural RAM
// with registered read sits on the main instance (DEPTH=16); a second
// instance with DEPTH=12 covers out-of-range addresses. Expected values come
// from a transaction-level model: a memory array plus the identity of the
// client served last.
`timescale 1ns/1ps
module tb_spram_arbiter;

    localparam int DW        = 8;
    localparam int DEPTH     = 16;
    localparam int AW        = 4;
    localparam int OOR_DEPTH = 12;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req, we;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    done;
    logic          err;
    logic [DW-1:0] rdata;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    logic [1:0]    o_req, o_we;
    logic [AW-1:0] o_addr0, o_addr1;
    logic [DW-1:0] o_wdata0, o_wdata1;
    logic [1:0]    o_done;
    logic          o_err;
    logic [DW-1:0] o_rdata;
    logic          o_ram_en;
    logic [AW-1:0] o_ram_addr;
    logic [DW-1:0] o_ram_wdata, o_ram_rdata;

`ifdef SPRAM_ARB_STATS_EN
    logic [15:0]   gnt_cnt0, gnt_cnt1, o_cnt0, o_cnt1;
`endif

    int            errors;
    int            checks;
    logic [DW-1:0] model_mem [DEPTH];
    int            last_served;
    logic          op_w [2];
    logic [AW-1:0] op_a [2];
    logic [DW-1:0] op_d [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spram_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done(done), .err(err), .rdata(rdata),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef SPRAM_ARB_STATS_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    spram_arbiter #(.DATA_WIDTH(DW), .DEPTH(OOR_DEPTH)) dut_oor (
        .clk(clk), .rst_n(rst_n), .req(o_req), .we(o_we),
        .addr0(o_addr0), .addr1(o_addr1), .wdata0(o_wdata0), .wdata1(o_wdata1),
        .done(o_done), .err(o_err), .rdata(o_rdata),
        .ram_en(o_ram_en), .ram_addr(o_ram_addr), .ram_wdata(o_ram_wdata), .ram_rdata(o_ram_rdata)
`ifdef SPRAM_ARB_STATS_EN
        , .gnt_cnt0(o_cnt0), .gnt_cnt1(o_cnt1)
`endif
    );

    assign o_ram_rdata = 8'h5A;

    // Single-port RAM with registered read output.
    logic [DW-1:0] ram_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (ram_en) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // Round-robin rule from the client's point of view.
    function automatic int rr_winner(input logic [1:0] pending);
        if (pending == 2'b11) return 1 - last_served;
        return pending[1] ? 1 : 0;
    endfunction

    task automatic set_client(input int c, input logic r, input logic w,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[c] = r;
        we[c]  = w;
        if (c == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
    endtask

    task automatic new_op(input int c);
        op_w[c] = 1'($urandom_range(1, 0));
        op_a[c] = AW'($urandom_range(DEPTH - 1, 0));
        op_d[c] = DW'($urandom);
        set_client(c, 1'b1, op_w[c], op_a[c], op_d[c]);
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        req = '0; we = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        o_req = '0; o_we = '0; o_addr0 = '0; o_addr1 = '0; o_wdata0 = '0; o_wdata1 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_served = 1;
        @(negedge clk);
    endtask

    // One transaction by a lone client, starting and ending in IDLE.
    task automatic run_single(input int c, input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input string tag);
        int         lat;
        int         en_cnt;
        logic [1:0] exp_done;
        lat = 0;
        en_cnt = 0;
        exp_done = 2'(1 << c);
        set_client(c, 1'b1, w, a, d);
        do begin
            @(negedge clk);
            lat++;
            if (ram_en === 1'b1) en_cnt++;
        end while (done === 2'b00 && lat < 8);
        set_client(c, 1'b0, w, a, d);
        checks++; if (done !== exp_done) begin errors++; $display("FAIL %s done: got %b want %b", tag, done, exp_done); end
        checks++; if (lat != (w ? 1 : 2)) begin errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, (w ? 1 : 2)); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s err: got %b want 0", tag, err); end
        checks++; if (ram_addr !== a) begin errors++; $display("FAIL %s ram_addr: got %h want %h", tag, ram_addr, a); end
        if (w) begin
            checks++; if (en_cnt != 1) begin errors++; $display("FAIL %s ram_en cycles: got %0d want 1", tag, en_cnt); end
            checks++; if (ram_wdata !== d) begin errors++; $display("FAIL %s ram_wdata: got %h want %h", tag, ram_wdata, d); end
            model_mem[a] = d;
        end else begin
            checks++; if (en_cnt != 0) begin errors++; $display("FAIL %s ram_en cycles: got %0d want 0", tag, en_cnt); end
            checks++; if (rdata !== model_mem[a]) begin errors++; $display("FAIL %s rdata: got %h want %h", tag, rdata, model_mem[a]); end
        end
        last_served = c;
        @(negedge clk);
        checks++;
        if (done !== 2'b00 || ram_en !== 1'b0 || rdata !== '0) begin
            errors++; $display("FAIL %s idle after done: done=%b ram_en=%b rdata=%h want 00/0/00", tag, done, ram_en, rdata);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = '0; we = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        o_req = '0; o_we = '0; o_addr0 = '0; o_addr1 = '0; o_wdata0 = '0; o_wdata1 = '0;
        repeat (2) @(negedge clk);
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset done: got %b want 00", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", err); end
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset ram_en: got %b want 0", ram_en); end
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset ram_addr: got %h want 0", ram_addr); end
        checks++; if (ram_wdata !== '0) begin errors++; $display("FAIL reset ram_wdata: got %h want 0", ram_wdata); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL reset rdata: got %h want 0", rdata); end
        checks++; if (o_done !== 2'b00 || o_err !== 1'b0) begin errors++; $display("FAIL reset oor outputs: done=%b err=%b want 00/0", o_done, o_err); end
        rst_n = 1'b1;
        last_served = 1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (done !== 2'b00 || ram_en !== 1'b0) begin errors++; $display("FAIL reset idle: done=%b ram_en=%b want 00/0", done, ram_en); end
        end
    endtask

    task automatic test_write_read;
        run_single(0, 1'b1, 4'd3, 8'hA5, "wr_a5");
        run_single(0, 1'b0, 4'd3, 8'h00, "rd_a5");
    endtask

    // Client 1 alone streams 16 writes (value = address) then 16 reads.
    task automatic test_back_to_back;
        int   since;
        logic w;
        for (int pass = 0; pass < 2; pass++) begin
            w = (pass == 0);
            for (int i = 0; i < DEPTH; i++) begin
                set_client(1, 1'b1, w, AW'(i), DW'(i));
                since = 0;
                do begin
                    @(negedge clk);
                    since++;
                end while (done === 2'b00 && since < 8);
                checks++; if (done !== 2'b10) begin errors++; $display("FAIL b2b[%0d] done: got %b want 10", i, done); end
                if (i == 0) begin
                    checks++; if (since != (w ? 1 : 2)) begin errors++; $display("FAIL b2b first latency: got %0d want %0d", since, (w ? 1 : 2)); end
                end else begin
                    checks++; if (since != (w ? 2 : 3)) begin errors++; $display("FAIL b2b[%0d] spacing: got %0d want %0d", i, since, (w ? 2 : 3)); end
                end
                if (w) model_mem[i] = DW'(i);
                else begin
                    checks++; if (rdata !== DW'(i)) begin errors++; $display("FAIL b2b[%0d] rdata: got %h want %h", i, rdata, DW'(i)); end
                end
                last_served = 1;
            end
            set_client(1, 1'b0, w, '0, '0);
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin;
        int         served;
        int         cyc;
        int         exp;
        apply_reset();
        op_w[0] = 1'b1; op_a[0] = 4'd7; op_d[0] = 8'h11;
        op_w[1] = 1'b1; op_a[1] = 4'd7; op_d[1] = 8'h22;
        set_client(0, 1'b1, op_w[0], op_a[0], op_d[0]);
        set_client(1, 1'b1, op_w[1], op_a[1], op_d[1]);
        served = 0;
        cyc = 0;
        while (served < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done !== 2'b00) begin
                exp = rr_winner(req);
                checks++; if (done !== 2'(1 << exp)) begin errors++; $display("FAIL rr order[%0d]: got %b want %b", served, done, 2'(1 << exp)); end
                model_mem[op_a[exp]] = op_d[exp];
                last_served = exp;
                set_client(exp, 1'b0, op_w[exp], op_a[exp], op_d[exp]);
                served++;
            end
        end
        checks++; if (served != 2) begin errors++; $display("FAIL rr completions: got %0d want 2", served); end
        @(negedge clk);
        run_single(0, 1'b0, 4'd7, 8'h00, "rr_read");
    endtask

    // Both clients request continuously with random operations.
    task automatic test_random_contention;
        int n;
        int cyc;
        int exp;
        n = 0;
        cyc = 0;
        new_op(0);
        new_op(1);
        while (n < 40 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            checks++; if (done === 2'b11) begin errors++; $display("FAIL rand both done: got %b", done); end
            checks++; if (done === 2'b00 && rdata !== '0) begin errors++; $display("FAIL rand rdata idle: got %h want 00", rdata); end
            checks++; if (ram_en === 1'b1 && done === 2'b00) begin errors++; $display("FAIL rand ram_en without done: got 1 want 0"); end
            if (done !== 2'b00) begin
                exp = rr_winner(2'b11);
                checks++; if (done !== 2'(1 << exp)) begin errors++; $display("FAIL rand winner[%0d]: got %b want %b", n, done, 2'(1 << exp)); end
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand err[%0d]: got %b want 0", n, err); end
                if (op_w[exp]) model_mem[op_a[exp]] = op_d[exp];
                else begin
                    checks++; if (rdata !== model_mem[op_a[exp]]) begin errors++; $display("FAIL rand rdata[%0d]: got %h want %h", n, rdata, model_mem[op_a[exp]]); end
                end
                last_served = exp;
                n++;
                if (n < 40) new_op(exp);
            end
        end
        req = 2'b00;
        checks++; if (n != 40) begin errors++; $display("FAIL rand completions: got %0d want 40", n); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random_single;
        int            c;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < 12; i++) begin
            c = int'($urandom_range(1, 0));
            w = 1'($urandom_range(1, 0));
            a = AW'($urandom_range(DEPTH - 1, 0));
            d = DW'($urandom);
            repeat ($urandom_range(3, 0)) @(negedge clk);
            run_single(c, w, a, d, "rand_single");
        end
    endtask

    task automatic test_reset_mid;
        run_single(0, 1'b1, 4'd5, 8'h5C, "mid_setup");
        set_client(0, 1'b1, 1'b1, 4'd5, 8'hFF);
        @(negedge clk);
        checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL mid access ram_en: got %b want 1", ram_en); end
        rst_n = 1'b0;
        req = 2'b00;
        #1;
        checks++; if (done !== 2'b00 || ram_en !== 1'b0) begin errors++; $display("FAIL mid abort: done=%b ram_en=%b want 00/0", done, ram_en); end
        @(negedge clk);
        checks++; if (done !== 2'b00 || ram_en !== 1'b0) begin errors++; $display("FAIL mid in reset: done=%b ram_en=%b want 00/0", done, ram_en); end
        rst_n = 1'b1;
        last_served = 1;
        repeat (2) begin
            @(negedge clk);
            checks++; if (done !== 2'b00) begin errors++; $display("FAIL mid after reset done: got %b want 00", done); end
        end
        run_single(0, 1'b0, 4'd5, 8'h00, "mid_read");
    endtask

    task automatic o_txn(input logic w, input logic [AW-1:0] a, input logic exp_err, input string tag);
        int lat;
        int en;
        lat = 0;
        en = 0;
        o_req = 2'b01; o_we = {1'b0, w}; o_addr0 = a; o_wdata0 = 8'h77;
        do begin
            @(negedge clk);
            lat++;
            if (o_ram_en === 1'b1) en++;
        end while (o_done === 2'b00 && lat < 8);
        o_req = 2'b00;
        checks++; if (o_done !== 2'b01) begin errors++; $display("FAIL %s done: got %b want 01", tag, o_done); end
        checks++; if (o_err !== exp_err) begin errors++; $display("FAIL %s err: got %b want %b", tag, o_err, exp_err); end
        checks++; if (lat != ((w || exp_err) ? 1 : 2)) begin errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, ((w || exp_err) ? 1 : 2)); end
        checks++; if (en != ((w && !exp_err) ? 1 : 0)) begin errors++; $display("FAIL %s ram_en cycles: got %0d want %0d", tag, en, ((w && !exp_err) ? 1 : 0)); end
        if (!w) begin
            checks++; if (o_rdata !== (exp_err ? 8'h00 : 8'h5A)) begin errors++; $display("FAIL %s rdata: got %h want %h", tag, o_rdata, (exp_err ? 8'h00 : 8'h5A)); end
        end
        @(negedge clk);
        checks++; if (o_done !== 2'b00 || o_ram_en !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL %s idle: done=%b ram_en=%b err=%b", tag, o_done, o_ram_en, o_err); end
    endtask

    task automatic test_out_of_range;
        o_txn(1'b1, 4'd13, 1'b1, "oor_wr13");
        o_txn(1'b0, 4'd13, 1'b1, "oor_rd13");
        o_txn(1'b1, 4'd12, 1'b1, "oor_wr12");
        o_txn(1'b1, 4'd11, 1'b0, "oor_wr11");
        o_txn(1'b0, 4'd11, 1'b0, "oor_rd11");
    endtask

`ifdef SPRAM_ARB_STATS_EN
    task automatic test_stats;
        apply_reset();
        checks++; if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin errors++; $display("FAIL stats after reset: got %0d/%0d want 0/0", gnt_cnt0, gnt_cnt1); end
        for (int i = 0; i < 5; i++) run_single(0, 1'b1, AW'(i), DW'(8'h30 + i), "stats_c0");
        for (int i = 0; i < 3; i++) run_single(1, 1'b0, AW'(i), 8'h00, "stats_c1");
        checks++; if (gnt_cnt0 !== 16'd5) begin errors++; $display("FAIL stats gnt_cnt0: got %0d want 5", gnt_cnt0); end
        checks++; if (gnt_cnt1 !== 16'd3) begin errors++; $display("FAIL stats gnt_cnt1: got %0d want 3", gnt_cnt1); end
        apply_reset();
        checks++; if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin errors++; $display("FAIL stats cleared: got %0d/%0d want 0/0", gnt_cnt0, gnt_cnt1); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        last_served = 1;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_round_robin();
        test_random_contention();
        test_random_single();
        test_reset_mid();
        test_out_of_range();
`ifdef SPRAM_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
